// File: rtl/solver_pkg.sv
// Shared definitions for the solver host: FSM state encoding and default sizing.
package solver_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam int DEF_W       = 8;
   localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/solver_host_edge_detect.sv
// Rising-edge detector: flags the cycle in which d goes from low to high.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   end

   assign rise = d && !d_q;
endmodule

// File: rtl/solver_host.sv
// Job host for an external solver: accepts operands, starts the solver, waits
// for completion or timeout, and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready for a job; operands captured on acceptance
// START | one-cycle solver start pulse, wait counter cleared
// WAIT  | waiting for a fresh rising edge of solve_done or timeout
// OUT   | result presented until the consumer accepts it
module solver_host
   import solver_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   output logic [W-1:0] op_x,
   output logic [W-1:0] op_a,
   output logic [W-1:0] op_b,
   output logic [W-1:0] op_c,
   output logic         solve_start,
   input  logic         solve_done,
   input  logic [W-1:0] solve_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_timeout,
   output logic         busy,
   output logic [7:0]   job_count
);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q;
   logic       done_rise;
   logic       done_evt;
   logic       tmo_hit;

   edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (solve_done),
      .rise (done_rise)
   );

   // A level left high by an earlier job never produces a rise, so only a
   // fresh edge seen while waiting can complete the current job.
   assign done_evt = done_rise && (state_q == WAIT);
   assign tmo_hit  = (state_q == WAIT) && (cnt_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (in_valid) state_d = START;
         START: state_d = WAIT;
         WAIT:  if (done_evt || tmo_hit) state_d = OUT;
         OUT:   if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else if (state_q == START) begin
         cnt_q <= 8'd0;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_x <= '0;
         op_a <= '0;
         op_b <= '0;
         op_c <= '0;
      end else if (state_q == IDLE && in_valid) begin
         op_x <= in_x;
         op_a <= in_a;
         op_b <= in_b;
         op_c <= in_c;
      end
   end

   // Completion is checked first so it wins over a coincident timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data    <= '0;
         out_timeout <= 1'b0;
      end else if (done_evt) begin
         out_data    <= solve_result;
         out_timeout <= 1'b0;
      end else if (tmo_hit) begin
         out_data    <= '0;
         out_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              job_count <= 8'd0;
      else if (state_q == OUT && out_ready) job_count <= job_count + 8'd1;
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign solve_start = (state_q == START);
   assign out_valid   = (state_q == OUT);
endmodule

// File: doc/solver_host.md
SOLVER_HOST -- requirements
Module: solver_host

Interface
REQ-001 Parameter W, default 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 16, max WAIT cycles before abort; legal range 2..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  job request valid.
REQ-006 in_ready  output  1  host can accept a job.
REQ-007 in_x, in_a, in_b, in_c  input  W each  job operands.
REQ-008 op_x, op_a, op_b, op_c  output  W each  registered operands presented to the solver.
REQ-009 solve_start  output  1  one-cycle start pulse to the solver.
REQ-010 solve_done  input  1  solver completion level; may stay high across jobs.
REQ-011 solve_result  input  W  solver result, valid while solve_done is high.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  W  captured result.
REQ-015 out_timeout  output  1  current out_data is from an aborted job.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 job_count  output  8  completed output handshakes, modulo 256.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT, OUT; all outputs registered or decoded from state only.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready capture in_x/a/b/c into op_x/a/b/c and go to START; else stay.
REQ-020 START: solve_start=1 for exactly this one cycle, wait counter cleared to 0; next state WAIT.
REQ-021 done_q SHALL register solve_done every cycle; a completion event is solve_done && !done_q.
REQ-022 WAIT: counter increments each cycle; on completion event capture solve_result into out_data, out_timeout=0, go to OUT.
REQ-023 WAIT: if counter == TIMEOUT-1 with no completion event, set out_data=0, out_timeout=1, go to OUT.
REQ-024 Completion event and timeout in the same cycle: completion wins, out_timeout=0.
REQ-025 Completion events outside WAIT SHALL be ignored; a level held high from a previous job SHALL NOT complete a new job.
REQ-026 OUT: out_valid=1; out_data and out_timeout held stable until out_valid&&out_ready; then job_count+1 (255 wraps to 0), go to IDLE.
REQ-027 in_ready=0 in START, WAIT, OUT; in_valid there has no effect.
REQ-028 op_* SHALL hold their value from capture until the next IDLE acceptance.
REQ-029 Minimum latency: accept at cycle N, solve_start at N+1, earliest out_valid at N+3.
REQ-030 Back-to-back: after OUT handshake at cycle M, a new job may be accepted at M+1.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, done_q 0, op_* 0, out_data 0, out_timeout 0, out_valid 0, solve_start 0, job_count 0, busy 0, in_ready 1, immediately and regardless of clock.
REQ-032 rst asserted mid-job SHALL abandon the job with no output handshake; the first cycle after release is IDLE.

Structure
REQ-033 State encoding (IDLE, START, WAIT, OUT) and default W/TIMEOUT constants SHALL live in a shared solver package.
REQ-034 The rising-edge detector (solve_done -> completion event) SHALL be a sub-module named edge_detect.
REQ-035 Single clock domain, no latches, no combinational path from out_ready or in_valid to any output.

Verification
REQ-036 Job x=3,a=2,b=5,c=1; solver pulses done at WAIT cycle 4 with result 0x2A -> out_valid, out_data=0x2A, out_timeout=0, job_count 0->1.
REQ-037 No completion for TIMEOUT=16 WAIT cycles -> out_valid with out_data=0, out_timeout=1 after exactly 16 WAIT cycles.
REQ-038 solve_done held high from previous job into next WAIT -> no completion until it falls and rises again.
REQ-039 out_ready low for 5 cycles in OUT -> out_data/out_timeout stable, in_ready=0, in_valid ignored; handshake on cycle 6.
REQ-040 rst pulsed during WAIT -> all outputs at REQ-031 values asynchronously; next job runs normally.
REQ-041 256 completed jobs -> job_count wraps 255->0.
